// File: rtl/lz77_dec_sched.sv
// Purpose: round-robin share of one LZ77 decoder between N requesters, one decoded block per grant.
// Latency: 1-cycle arbitration in IDLE; token and decoded-byte paths are combinational pass-through.
// Backpressure: req_ready mirrors dec_i_ready for the owner only; dec_o_ready mirrors out_ready while busy.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_data/req_en/req_last      per-requester token bytes (8 bits per requester), valid, end-of-block
//   req_ready                     per-requester accept, only ever high for the current owner in FEED
//   dec_i_data/dec_i_en/dec_i_ready   token stream towards the decoder
//   dec_o_data/dec_o_en/dec_o_ready   decoded stream from the decoder
//   out_data/out_en/out_id/out_ready  decoded stream to downstream, tagged with its owner
//   grant_id, busy, err           current owner, FEED/DRAIN indicator, sticky error
module lz77_dec_sched #(
    parameter int N         = 2,
    parameter int BLOCK_LEN = 4096,
    parameter int TIMEOUT   = 1024,
    parameter int IDW       = (N > 1) ? $clog2(N) : 1,
    parameter int CW        = $clog2(BLOCK_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_en,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     dec_i_data,
    output logic           dec_i_en,
    input  logic           dec_i_ready,
    input  logic [7:0]     dec_o_data,
    input  logic           dec_o_en,
    output logic           dec_o_ready,
    output logic [7:0]     out_data,
    output logic           out_en,
    output logic [IDW-1:0] out_id,
    input  logic           out_ready,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  beat_cnt;
    logic [TW-1:0]  idle_cnt;

    logic [IDW-1:0] pick;
    logic           found;
    logic           out_beat;
    logic           in_accept;
    logic           last_acc;
    logic           beat_done;
    logic           idle_hit;
    logic           release_grant;
    logic           set_err;

    // Circular search starting at rr_ptr for the first requester with data.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_en[(int'(rr_ptr) + k) % N]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    // Datapath and handshakes; everything is gated by state so that reset
    // (state forced to IDLE) drives all ready/enable outputs low.
    always_comb begin
        busy        = (state_q != IDLE);
        dec_i_data  = req_data[8*int'(grant_id) +: 8];
        dec_i_en    = (state_q == FEED) && req_en[grant_id];
        req_ready   = '0;
        if (state_q == FEED) begin
            req_ready[grant_id] = dec_i_ready;
        end
        dec_o_ready = busy && out_ready;
        out_en      = busy && dec_o_en;
        out_data    = dec_o_data;
        out_id      = grant_id;
    end

    assign out_beat  = dec_o_en && dec_o_ready;
    assign in_accept = dec_i_en && dec_i_ready;
    assign last_acc  = in_accept && req_last[grant_id];
    // The beat that takes beat_cnt to BLOCK_LEN ends the block this cycle.
    assign beat_done = out_beat && (beat_cnt == CW'(BLOCK_LEN - 1));
    // A beat in the same cycle as the threshold wins, hence the !out_beat.
    assign idle_hit  = !out_beat && (idle_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        release_grant = 1'b0;
        set_err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_en) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (beat_done) begin
                    // Block full before req_last: overrun unless last arrives together.
                    state_d       = IDLE;
                    release_grant = 1'b1;
                    set_err       = !last_acc;
                end else if (last_acc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_done) begin
                    state_d       = IDLE;
                    release_grant = 1'b1;
                end else if (idle_hit) begin
                    state_d       = IDLE;
                    release_grant = 1'b1;
                    set_err       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && state_d == FEED) begin
                grant_id <= pick;
                beat_cnt <= '0;
            end else if (out_beat) begin
                beat_cnt <= beat_cnt + CW'(1);
            end

            if (state_q == FEED && state_d == DRAIN) begin
                idle_cnt <= '0;
            end else if (state_q == DRAIN) begin
                if (out_beat) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != TW'(TIMEOUT)) begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end

            if (set_err) begin
                err <= 1'b1;
            end

            if (release_grant) begin
                rr_ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lz77_dec_sched.sv
module tb_lz77_dec_sched;

    localparam int N   = 2;
    localparam int BL  = 16;
    localparam int TO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d0 = 8'h00, d1 = 8'h00;
    logic        e0 = 1'b0, e1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [15:0] req_data;
    logic [1:0]  req_en, req_last, req_ready;
    logic [7:0]  dec_i_data, dec_o_data, out_data;
    logic        dec_i_en, dec_i_ready, dec_o_en, dec_o_ready;
    logic        out_en, out_ready = 1'b1;
    logic [0:0]  out_id, grant_id;
    logic        busy, err;

    assign req_data = {d1, d0};
    assign req_en   = {e1, e0};
    assign req_last = {l1, l0};

    int checks = 0;
    int errors = 0;
    int beat_total = 0;
    int rdy_viol = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [0:0] grant_log[$];
    logic       busy_q = 1'b0;
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    lz77_dec_sched #(.N(N), .BLOCK_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_en(req_en), .req_last(req_last), .req_ready(req_ready),
        .dec_i_data(dec_i_data), .dec_i_en(dec_i_en), .dec_i_ready(dec_i_ready),
        .dec_o_data(dec_o_data), .dec_o_en(dec_o_en), .dec_o_ready(dec_o_ready),
        .out_data(out_data), .out_en(out_en), .out_id(out_id), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    // Decoder stand-in: literal tokens only (0x00 followed by the byte), one-entry output buffer.
    logic       dm_full, dm_lit;
    logic [7:0] dm_byte;
    assign dec_i_ready = !dm_full;
    assign dec_o_en    = dm_full;
    assign dec_o_data  = dm_byte;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_full <= 1'b0;
            dm_lit  <= 1'b0;
            dm_byte <= 8'h00;
        end else begin
            if (dec_o_en && dec_o_ready) dm_full <= 1'b0;
            if (dec_i_en && dec_i_ready) begin
                if (dm_lit) begin
                    dm_byte <= dec_i_data;
                    dm_full <= 1'b1;
                    dm_lit  <= 1'b0;
                end else if (dec_i_data == 8'h00) begin
                    dm_lit <= 1'b1;
                end
            end
        end
    end

    // Scoreboard consumer and protocol monitor.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            busy_q = 1'b0;
        end else begin
            if (out_en && out_ready) begin
                beat_total++;
                checks++;
                if (out_id == 1'b0) begin
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected id=0 got %h, required no beat", out_data);
                    end else begin
                        exp_b = q0.pop_front();
                        if (out_data !== exp_b) begin
                            errors++;
                            $display("FAIL sb_data id=0 got %h required %h", out_data, exp_b);
                        end
                    end
                end else begin
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected id=1 got %h, required no beat", out_data);
                    end else begin
                        exp_b = q1.pop_front();
                        if (out_data !== exp_b) begin
                            errors++;
                            $display("FAIL sb_data id=1 got %h required %h", out_data, exp_b);
                        end
                    end
                end
            end
            if (busy && grant_id == 1'b0 && req_ready[1]) rdy_viol++;
            if (busy && !busy_q) grant_log.push_back(grant_id);
            busy_q = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int i, input logic [7:0] b, input logic last, input logic en);
        if (i == 0) begin d0 = b; l0 = last; e0 = en; end
        else        begin d1 = b; l1 = last; e1 = en; end
    endtask

    task automatic send_byte(input int i, input logic [7:0] b, input logic last);
        bit ok = 1'b0;
        drive(i, b, last, 1'b1);
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req=%0d byte=%h not accepted, required within 3000 cycles", i, b);
        end
        drive(i, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_literal(input int i, input logic [7:0] b, input logic last);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
        send_byte(i, 8'h00, 1'b0);
        send_byte(i, b, last);
    endtask

    task automatic send_block(input int i, input logic [7:0] base, input int n, input logic with_last);
        for (int k = 0; k < n; k++) send_literal(i, base + 8'(k), with_last && (k == n - 1));
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            if (!busy && q0.size() == 0 && q1.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%0b pending=%0d, required idle within %0d cycles", busy, q0.size() + q1.size(), budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, err, grant_id} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state busy/err/grant got %b required 000", {busy, err, grant_id});
        end
        checks++;
        if ({req_ready, dec_i_en, dec_o_ready, out_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshakes got %b required 00000", {req_ready, dec_i_en, dec_o_ready, out_en});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_block();
        int bt0;
        reset_dut();
        bt0 = beat_total;
        fork
            send_block(0, 8'h10, BL, 1'b1);
            begin
                int n = 0;
                bit done = 1'b0;
                for (int t = 0; t < 2000 && !done; t++) begin
                    @(negedge clk);
                    if (out_en && out_ready) begin
                        n++;
                        if (n == BL) begin
                            checks++;
                            if (busy !== 1'b1) begin
                                errors++;
                                $display("FAIL single_busy_at_last got %b required 1", busy);
                            end
                            @(negedge clk);
                            checks++;
                            if (busy !== 1'b0) begin
                                errors++;
                                $display("FAIL single_busy_after_last got %b required 0", busy);
                            end
                            done = 1'b1;
                        end
                    end
                end
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL single_beats got %0d required %0d", n, BL);
                end
            end
        join
        wait_idle(200);
        checks++;
        if (beat_total - bt0 != BL || err !== 1'b0) begin
            errors++;
            $display("FAIL single_total beats=%0d err=%b required %0d err=0", beat_total - bt0, err, BL);
        end
        // Both request after release: the pointer must now favour requester 1.
        drive(0, 8'h00, 1'b0, 1'b1);
        drive(1, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL single_next_grant busy=%b grant=%0d required busy=1 grant=1", busy, grant_id);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        grant_log.delete();
        rdy_viol = 0;
        fork
            begin send_block(0, 8'h20, BL, 1'b1); send_block(0, 8'h30, BL, 1'b1); end
            begin send_block(1, 8'h80, BL, 1'b1); send_block(1, 8'h90, BL, 1'b1); end
        join
        wait_idle(200);
        checks++;
        if (grant_log.size() != 4) begin
            errors++;
            $display("FAIL rr_grant_count got %0d required 4", grant_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grant_log[k] !== 1'(k % 2)) begin
                    errors++;
                    $display("FAIL rr_grant_order slot=%0d got %0d required %0d", k, grant_log[k], k % 2);
                end
            end
        end
        checks++;
        if (rdy_viol != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rr_isolation ready1_while_owner0=%0d err=%b required 0 and 0", rdy_viol, err);
        end
    endtask

    task automatic test_stall();
        int bt0;
        reset_dut();
        bt0 = beat_total;
        send_block(0, 8'h40, BL - 1, 1'b0);
        q0.push_back(8'h4F);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h4F, 1'b1);
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || beat_total - bt0 != BL - 1) begin
            errors++;
            $display("FAIL stall_hold busy=%b err=%b beats=%0d required 1 0 %0d", busy, err, beat_total - bt0, BL - 1);
        end
        out_ready = 1'b1;
        wait_idle(200);
        checks++;
        if (err !== 1'b0 || beat_total - bt0 != BL) begin
            errors++;
            $display("FAIL stall_resume err=%b beats=%0d required 0 %0d", err, beat_total - bt0, BL);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        drive(1, 8'h00, 1'b0, 1'b1);
        send_block(0, 8'h50, BL - 1, 1'b0);
        q0.push_back(8'h5F);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h5F, 1'b1);
        out_ready = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early err=%b busy=%b required 0 1", err, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire err=%b busy=%b required 1 0", err, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL timeout_handover busy=%b grant=%0d required 1 1", busy, grant_id);
        end
    endtask

    task automatic test_overrun();
        int bt0;
        reset_dut();
        bt0 = beat_total;
        fork
            begin
                send_block(0, 8'h60, BL + 1, 1'b0);
                send_block(0, 8'h71, BL - 1, 1'b1);
            end
            begin
                int n = 0;
                bit done = 1'b0;
                for (int t = 0; t < 2000 && !done; t++) begin
                    @(negedge clk);
                    if (out_en && out_ready) begin
                        n++;
                        if (n == BL) begin
                            checks++;
                            if (err !== 1'b0 || busy !== 1'b1) begin
                                errors++;
                                $display("FAIL overrun_pre err=%b busy=%b required 0 1", err, busy);
                            end
                            @(negedge clk);
                            checks++;
                            if (err !== 1'b1 || busy !== 1'b0) begin
                                errors++;
                                $display("FAIL overrun_release err=%b busy=%b required 1 0", err, busy);
                            end
                            @(negedge clk);
                            checks++;
                            if (busy !== 1'b1 || grant_id !== 1'b0) begin
                                errors++;
                                $display("FAIL overrun_regrant busy=%b grant=%0d required 1 0", busy, grant_id);
                            end
                            done = 1'b1;
                        end
                    end
                end
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL overrun_beats got %0d required %0d", n, BL);
                end
            end
        join
        wait_idle(300);
        checks++;
        if (beat_total - bt0 != 2 * BL || err !== 1'b1) begin
            errors++;
            $display("FAIL overrun_total beats=%0d err=%b required %0d 1", beat_total - bt0, err, 2 * BL);
        end
    endtask

    task automatic test_reset_midblock();
        reset_dut();
        send_block(0, 8'h01, BL, 1'b1);
        wait_idle(200);
        send_literal(1, 8'hB0, 1'b0);
        send_literal(1, 8'hB1, 1'b0);
        send_byte(1, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre busy=%b grant=%0d required 1 1", busy, grant_id);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, err, grant_id} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_state busy/err/grant got %b required 000", {busy, err, grant_id});
        end
        checks++;
        if ({req_ready, dec_i_en, dec_o_ready, out_en} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_handshakes got %b required 00000", {req_ready, dec_i_en, dec_o_ready, out_en});
        end
        drive(0, 8'h00, 1'b0, 1'b1);
        drive(1, 8'h00, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next_grant busy=%b grant=%0d required 1 0", busy, grant_id);
        end
        reset_dut();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_round_robin();
        test_stall();
        test_timeout();
        test_overrun();
        test_reset_midblock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lz77_dec_sched.md
Name: lz77_dec_sched

Overview:
- Round-robin scheduler that shares one LZ77 decoder instance between N compressed-byte requesters.
- Grants the decoder to one requester per 4096-byte block. Forwards that requester's token bytes to the decoder input. Routes the decoded byte stream back tagged with the owner id.
- Releases the decoder only after the full block has drained.
- Sits between the stream front-ends and the decoder's i_*/o_* valid-ready ports.

Parameters:
- N, 2, number of requesters (2..8).
- BLOCK_LEN, 4096, decoded bytes per block; must match the decoder buffer depth.
- TIMEOUT, 1024, max cycles in DRAIN without an output beat before forced release.
- IDW, $clog2(N) (min 1), width of the grant/output id.
- CW, $clog2(BLOCK_LEN+1), width of the output beat counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_data  in  8*N  token byte per requester; requester i uses bits [8i+7:8i]
- req_en  in  N  token byte valid per requester
- req_last  in  N  marks the final token byte of the requester's block
- req_ready  out  N  token byte accepted when req_en[i] & req_ready[i]
- dec_i_data  out  8  to decoder i_data
- dec_i_en  out  1  to decoder i_en
- dec_i_ready  in  1  from decoder i_ready
- dec_o_data  in  8  from decoder o_data
- dec_o_en  in  1  from decoder o_en
- dec_o_ready  out  1  to decoder o_ready
- out_data  out  8  decoded byte
- out_en  out  1  decoded byte valid
- out_id  out  IDW  owner of out_data
- out_ready  in  1  downstream accept
- grant_id  out  IDW  current owner, valid when busy=1
- busy  out  1  high in FEED or DRAIN
- err  out  1  sticky error flag, cleared only by rst

Behaviour:
- Reset (rst=1, async): state=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0; idle_cnt=0; err=0; busy=0.
- Reset forces all ready/en outputs low. Asserting rst mid-block abandons the block with no flush. The system must reset the decoder in the same cycle.
- States:
  - IDLE: if any req_en is high, grant_id <= first i at or after rr_ptr (circular) with req_en[i]=1; go to FEED. Arbitration latency is 1 cycle. No requester is accepted while in IDLE.
  - FEED: dec_i_data=req_data[grant_id]; dec_i_en=req_en[grant_id]; req_ready[grant_id]=dec_i_ready; all other req_ready=0.
    - On an accepted beat with req_last[grant_id]=1, go to DRAIN.
  - DRAIN: inputs blocked (dec_i_en=0, req_ready=0).
    - Go to IDLE when beat_cnt reaches BLOCK_LEN.
    - If idle_cnt reaches TIMEOUT first: set err, go to IDLE.
- Output path in FEED and DRAIN is combinational pass-through:
  - out_data=dec_o_data; out_en=dec_o_en; dec_o_ready=out_ready; out_id=grant_id.
  - In IDLE: out_en=0 and dec_o_ready=0.
- beat_cnt increments on each dec_o_en & dec_o_ready. It clears on entry to FEED.
- idle_cnt behaviour:
  - Increments each DRAIN cycle without an output beat.
  - Clears on any output beat and on entry to DRAIN.
  - Saturates at TIMEOUT.
- Early overrun: beat_cnt reaches BLOCK_LEN while still in FEED (req_last not yet seen).
  - Set err and go to IDLE.
  - The unsent remainder stays pending at the requester and is forwarded under its next grant.
- Release: on every transition to IDLE, rr_ptr <= (grant_id+1) mod N. The next requester cannot be granted earlier than the cycle after release.
- Simultaneous events in the same cycle:
  - An accepted req_last beat together with beat_cnt reaching BLOCK_LEN counts as normal completion: go to IDLE, err unchanged.
  - An output beat and the TIMEOUT threshold: the beat wins and idle_cnt clears.
- Requesters must hold req_en/req_data stable until accepted. The scheduler never drops or duplicates an accepted byte.

Test Plan:
- N=2, BLOCK_LEN=16, req 0 only: 16 literal tokens (0x00,b) with req_last on the final byte, out_ready=1 -> 16 out beats with out_id=0 in order; busy falls the cycle after beat 16; rr_ptr=1.
- req_en[0] and req_en[1] both high from reset release -> grant order 0,1,0,1 across four blocks; req_ready[1] stays 0 throughout each block owned by 0.
- out_ready held low for 20 cycles mid-DRAIN (TIMEOUT=64) -> decoder stalls, no beat lost, no err; block completes after out_ready returns.
- out_ready low for 64 consecutive DRAIN cycles -> err=1 exactly when idle_cnt reaches 64; state IDLE; grant passes to the other requester.
- Requester sends 17 decodable bytes' worth of tokens with no req_last -> err=1 at beat 16, immediate release; the remaining token bytes are accepted under that requester's next grant.
- rst pulsed in FEED after 5 accepted bytes -> all outputs reach reset values asynchronously; next grant after rst falls goes to requester 0.
